// File: rtl/imem_loader.sv
// Host-side program loader: packs a big-endian byte stream into a 1024-word
// instruction memory, serves combinational fetches, and drives CPU run control.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              stop,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       ins,
  output logic              enable,
  output logic              start,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      byte_idx_r;
  logic [23:0]     asm_r;          // upper three bytes of the word under assembly
  logic [ADDR_W:0] word_count_r;   // doubles as the write pointer
  logic            err_overflow_r;
  logic            enable_r;
  logic            start_r;
  logic            s_ready_r;
  logic            busy_r;
  logic            accept_s;
  logic            full_s;
  logic            write_s;
  logic [31:0]     asm_word_s;
  logic [31:0]     mem_r [DEPTH];

  // Next-state decode, byte placement and write qualification.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    write_s  = 1'b0;
    full_s   = (word_count_r == DEPTH_C);
    case (byte_idx_r)
      2'd0:    asm_word_s = {s_data, 24'h00_0000};
      2'd1:    asm_word_s = {asm_r[23:16], s_data, 16'h0000};
      2'd2:    asm_word_s = {asm_r[23:8], s_data, 8'h00};
      2'd3:    asm_word_s = {asm_r[23:0], s_data};
      default: asm_word_s = 32'h0000_0000;
    endcase
    case (state_r)
      ST_IDLE: begin
        if (load_req) state_s = ST_LOAD;
        else          state_s = ST_IDLE;
      end
      ST_LOAD: begin
        accept_s = s_valid;
        // A final byte flushes a partial word, zero-padded in its low bytes.
        write_s  = s_valid && !full_s && (s_last || (byte_idx_r == 2'd3));
        if (s_valid && s_last) state_s = ST_ARM;
        else                   state_s = ST_LOAD;
      end
      ST_ARM: state_s = ST_RUN;
      ST_RUN: begin
        if (stop) state_s = ST_IDLE;
        else      state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, load counters and registered run-control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      byte_idx_r     <= 2'd0;
      asm_r          <= 24'h00_0000;
      word_count_r   <= '0;
      err_overflow_r <= 1'b0;
      enable_r       <= 1'b0;
      start_r        <= 1'b0;
      s_ready_r      <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r   <= state_s;
      enable_r  <= (state_s == ST_ARM) || (state_s == ST_RUN);
      start_r   <= (state_s == ST_ARM);
      s_ready_r <= (state_s == ST_LOAD);
      busy_r    <= (state_s == ST_LOAD);
      if ((state_r == ST_IDLE) && load_req) begin
        byte_idx_r     <= 2'd0;
        asm_r          <= 24'h00_0000;
        word_count_r   <= '0;
        err_overflow_r <= 1'b0;
      end else if (accept_s) begin
        if (full_s) begin
          err_overflow_r <= 1'b1;
        end else if (write_s) begin
          word_count_r <= word_count_r + (ADDR_W+1)'(1);
          byte_idx_r   <= 2'd0;
          asm_r        <= 24'h00_0000;
        end else begin
          asm_r      <= asm_word_s[31:8];
          byte_idx_r <= byte_idx_r + 2'd1;
        end
      end
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (write_s) mem_r[word_count_r[ADDR_W-1:0]] <= asm_word_s;
  end

  assign ins          = ({1'b0, i_addr} < word_count_r) ? mem_r[i_addr] : 32'h0000_0000;
  assign s_ready      = s_ready_r;
  assign enable       = enable_r;
  assign start        = start_r;
  assign busy         = busy_r;
  assign word_count   = word_count_r;
  assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed tables, corner-case sequences
// and randomized loads checked against a byte-stream reference model.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        stop = 1'b0;
  logic [9:0]  i_addr = 10'd0;
  logic [31:0] ins;
  logic        enable;
  logic        start;
  logic        busy;
  logic [10:0] word_count;
  logic        err_overflow;

  int total = 0;
  int bad = 0;
  logic [7:0] prog [$];

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] exp_ins;
  } vec_t;
  vec_t vecs [7];

  imem_loader dut (
    .clock(clock), .reset(reset), .load_req(load_req), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .stop(stop),
    .i_addr(i_addr), .ins(ins), .enable(enable), .start(start), .busy(busy),
    .word_count(word_count), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: words are consecutive 4-byte groups of the program, big-endian,
  // last group zero-padded, at most 1024 of them; anything beyond reads 0.
  function automatic int exp_count();
    int n = prog.size();
    int c = (n + 3) / 4;
    return (c > 1024) ? 1024 : c;
  endfunction

  function automatic logic [31:0] exp_word(input int addr);
    logic [31:0] w = 32'h0;
    if (addr >= exp_count()) return 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (4 * addr + b < prog.size()) w = w | (32'(prog[4 * addr + b]) << (24 - 8 * b));
    end
    return w;
  endfunction

  task automatic sweep(input string name);
    for (int a = 0; a < 1024; a++) begin
      i_addr = 10'(a);
      #1;
      check(name, ins, exp_word(a));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prog(input bit gaps);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("busy_in_load", 32'(busy), 32'd1);
    check("wc_cleared", 32'(word_count), 32'd0);
    check("err_cleared", 32'(err_overflow), 32'd0);
    check("ready_in_load", 32'(s_ready), 32'd1);
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1;
      s_data  = prog[i];
      s_last  = (i == prog.size() - 1);
      // stop must not disturb a load in progress
      stop    = (i == 1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      stop    = 1'b0;
    end
    check("arm_start", 32'(start), 32'd1);
    check("arm_enable", 32'(enable), 32'd1);
    check("arm_busy", 32'(busy), 32'd0);
    check("wc_final", 32'(word_count), 32'(exp_count()));
    check("err_final", 32'(err_overflow), 32'(prog.size() > 4096));
    tick();
    check("run_start", 32'(start), 32'd0);
    check("run_enable", 32'(enable), 32'd1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_enable", 32'(enable), 32'd0);
    check("stop_start", 32'(start), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{10'd0, 32'h8C01_0004};
    vecs[1] = '{10'd1, 32'h0022_1820};
    vecs[2] = '{10'd2, 32'h0000_0000};
    vecs[3] = '{10'd1023, 32'h0000_0000};
    vecs[4] = '{10'd0, 32'h1122_3344};
    vecs[5] = '{10'd1, 32'h5566_0000};
    vecs[6] = '{10'd2, 32'h0000_0000};

    // reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    prog = {};
    sweep("rst_ins");

    // two full words
    prog = {8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    load_prog(1'b0);
    for (int i = 0; i < 4; i++) begin
      i_addr = vecs[i].addr;
      #1;
      check("vec_prog1", ins, vecs[i].exp_ins);
    end
    tick();
    check("enable_held", 32'(enable), 32'd1);
    // load_req ignored in RUN
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("run_ignores_load", 32'(busy), 32'd0);
    check("run_still_enabled", 32'(enable), 32'd1);
    do_stop();

    // partial last word, without and with gaps
    prog = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int g = 0; g < 2; g++) begin
      load_prog(g[0]);
      for (int i = 4; i < 7; i++) begin
        i_addr = vecs[i].addr;
        #1;
        check("vec_prog2", ins, vecs[i].exp_ins);
      end
      do_stop();
    end

    // overflow: 4100 bytes
    prog = {};
    for (int i = 0; i < 4100; i++) prog.push_back(8'($urandom));
    load_prog(1'b0);
    i_addr = 10'd1023;
    #1;
    check("ovf_last_word", ins, {prog[4092], prog[4093], prog[4094], prog[4095]});
    sweep("ovf_sweep");
    do_stop();
    check("stop_keeps_err", 32'(err_overflow), 32'd1);
    sweep("after_stop_sweep");

    // randomized loads against the model
    for (int t = 0; t < 8; t++) begin
      prog = {};
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) prog.push_back(8'($urandom));
      load_prog(1'($urandom));
      sweep("rand_sweep");
      do_stop();
    end

    // reset in the middle of a load
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hA0 + i);
      tick();
    end
    s_valid = 1'b0;
    check("midload_wc", 32'(word_count), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_addr = 10'd0;
    #1;
    check("rst_mid_ready", 32'(s_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wc", 32'(word_count), 32'd0);
    check("rst_mid_ins0", ins, 32'h0);
    prog = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    load_prog(1'b1);
    sweep("post_reset_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
